// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready pipeline stage with optional skid buffer, flush and bubble fill
module pipe_stage_reg #(
  parameter int              DATA_W     = 64,
  parameter bit              SKID       = 1'b1,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);
  logic              mv_q, mv_d, sv_q, sv_d;
  logic [DATA_W-1:0] md_q, md_d, sd_q, sd_d;
  logic              accept, emit;
  assign in_ready  = SKID ? (!sv_q && !rst) : ((!mv_q || out_ready) && !rst);
  assign accept    = in_valid && in_ready;
  assign emit      = mv_q && out_ready;
  assign out_valid = mv_q;
  assign out_data  = mv_q ? md_q : BUBBLE_VAL;
  assign count     = {1'b0, mv_q} + {1'b0, sv_q};
  always_comb begin
    mv_d = mv_q;
    sv_d = sv_q;
    md_d = md_q;
    sd_d = sd_q;
    if (flush) begin
      mv_d = 1'b0;
      sv_d = 1'b0;
    end else if (SKID) begin
      if (emit && sv_q) begin
        md_d = sd_q;
        sv_d = 1'b0;
      end else if (emit) begin
        mv_d = accept;
        md_d = accept ? in_data : md_q;
      end else if (accept && !mv_q) begin
        mv_d = 1'b1;
        md_d = in_data;
      end else if (accept) begin
        sv_d = 1'b1;
        sd_d = in_data;
      end
    end else begin
      sv_d = 1'b0;
      mv_d = accept ? 1'b1 : (emit ? 1'b0 : mv_q);
      md_d = accept ? in_data : md_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mv_q <= 1'b0;
      sv_q <= 1'b0;
      md_q <= BUBBLE_VAL;
      sd_q <= BUBBLE_VAL;
    end else begin
      mv_q <= mv_d;
      sv_q <= sv_d;
      md_q <= md_d;
      sd_q <= sd_d;
    end
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench driving a skid (a_) and a non-skid (b_) stage with shared stimulus
module tb_pipe_stage_reg;
  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [15:0] in_data;
  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [15:0] a_out_data, b_out_data;
  logic [1:0]  a_count, b_count;
  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic        seen22 = 1'b0;
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  pipe_stage_reg #(.DATA_W(16), .SKID(1'b1), .BUBBLE_VAL(16'hDEAD)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .count(a_count)
  );
  pipe_stage_reg #(.DATA_W(16), .SKID(1'b0), .BUBBLE_VAL(16'hBEEF)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .count(b_count)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step(input logic v, input logic [15:0] d, input logic r, input logic f);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    @(negedge clk);
  endtask
  always @(negedge clk) begin : mon_a
    logic [15:0] e;
    if (a_out_valid && out_ready) begin
      checks++;
      if (a_out_data == 16'h22) seen22 = 1'b1;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_pop: got %0h expected nothing", a_out_data);
      end else begin
        e = qa.pop_front();
        if (a_out_data !== e) begin
          errors++;
          $display("FAIL a_pop: got %0h expected %0h", a_out_data, e);
        end
      end
    end
    if (rst || flush) qa.delete();
    else if (in_valid && a_in_ready) qa.push_back(in_data);
  end
  always @(negedge clk) begin : mon_b
    logic [15:0] e;
    if (b_out_valid && out_ready) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_pop: got %0h expected nothing", b_out_data);
      end else begin
        e = qb.pop_front();
        if (b_out_data !== e) begin
          errors++;
          $display("FAIL b_pop: got %0h expected %0h", b_out_data, e);
        end
      end
    end
    if (rst || flush) qb.delete();
    else if (in_valid && b_in_ready) qb.push_back(in_data);
  end
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'hAAAA;
    out_ready = 1'b0;
    flush     = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_a_in_ready", a_in_ready, 0);
      chk("rst_a_out_valid", a_out_valid, 0);
      chk("rst_a_out_data", a_out_data, 16'hDEAD);
      chk("rst_a_count", a_count, 0);
      chk("rst_b_in_ready", b_in_ready, 0);
      chk("rst_b_out_data", b_out_data, 16'hBEEF);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rel_a_in_ready", a_in_ready, 1);
    chk("rel_b_in_ready", b_in_ready, 1);
    step(1, 16'h1, 1, 0);
    chk("str_c1_count", a_count, 0);
    step(1, 16'h2, 1, 0);
    chk("str_d1", a_out_data, 16'h1);
    chk("str_c2_count", a_count, 1);
    chk("str_c2_ready", a_in_ready, 1);
    step(1, 16'h3, 1, 0);
    chk("str_d2", a_out_data, 16'h2);
    chk("str_c3_count", a_count, 1);
    chk("str_c3_ready", a_in_ready, 1);
    step(0, 16'h0, 1, 0);
    chk("str_d3", a_out_data, 16'h3);
    chk("str_c4_count", a_count, 1);
    step(0, 16'h0, 1, 0);
    chk("str_empty_valid", a_out_valid, 0);
    step(1, 16'h10, 0, 0);
    step(1, 16'h11, 0, 0);
    chk("bp_c2_count", a_count, 1);
    chk("bp_b_ready_low", b_in_ready, 0);
    step(1, 16'h12, 0, 0);
    chk("bp_full_count", a_count, 2);
    chk("bp_full_ready", a_in_ready, 0);
    step(1, 16'h12, 1, 0);
    chk("bp_out10", a_out_data, 16'h10);
    chk("bp_out10_ready", a_in_ready, 0);
    step(1, 16'h12, 1, 0);
    chk("bp_out11", a_out_data, 16'h11);
    chk("bp_out11_count", a_count, 1);
    step(0, 16'h0, 1, 0);
    chk("bp_out12", a_out_data, 16'h12);
    chk("bp_out12_valid", a_out_valid, 1);
    step(0, 16'h0, 1, 0);
    step(0, 16'h0, 1, 0);
    step(1, 16'h20, 0, 0);
    step(1, 16'h21, 0, 0);
    step(1, 16'h22, 0, 1);
    chk("fl_pre_count", a_count, 2);
    step(0, 16'h0, 0, 0);
    chk("fl_count", a_count, 0);
    chk("fl_valid", a_out_valid, 0);
    chk("fl_bubble", a_out_data, 16'hDEAD);
    chk("fl_b_bubble", b_out_data, 16'hBEEF);
    step(0, 16'h0, 1, 0);
    step(0, 16'h0, 1, 0);
    chk("fl_no22", seen22, 0);
    step(1, 16'h30, 0, 0);
    step(1, 16'h31, 1, 0);
    chk("sim_out30", a_out_data, 16'h30);
    chk("sim_c1", a_count, 1);
    step(0, 16'h0, 1, 0);
    chk("sim_out31", a_out_data, 16'h31);
    chk("sim_count", a_count, 1);
    chk("sim_ready", a_in_ready, 1);
    step(0, 16'h0, 1, 0);
    step(1, 16'h3F, 0, 0);
    step(0, 16'h0, 0, 0);
    chk("ns_ready_low", b_in_ready, 0);
    chk("ns_count", b_count, 1);
    step(1, 16'h40, 1, 0);
    chk("ns_ready_comb", b_in_ready, 1);
    step(0, 16'h0, 1, 0);
    chk("ns_out40", b_out_data, 16'h40);
    chk("ns_a_out40", a_out_data, 16'h40);
    for (int i = 0; i < 4; i++) step(0, 16'h0, 1, 0);
    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
